dat_read: RTL and testbench
===========================

Name: dat_read

Overview:
- SD host-side data-block receiver: the card-to-host counterpart of the block-write path.
- After start_i, waits for the card's start bit on DAT, deserializes block_size_i bytes on a 1- or 4-bit bus, and emits 32-bit words to the buffer side.
- Checks the per-lane CRC16 and the end bit, then pulses done_o with error flags.
- Sits beside the write path in the SD clock domain; the data buffer consumes data_o/data_valid_o.

Parameters:
MaxBlockBitSize, 12, width of block_size_i (block length in bytes)
TimeoutCycles, 65535, sd clocks to wait for start bit (used only with READ_TIMEOUT_EN)

Ports:
sd_clk_i  in  1  SD clock; all state on rising edge
rst_ni  in  1  asynchronous active-low reset
dat_i  in  4  DAT[3:0] from card (DAT0 = bit 0)
start_i  in  1  one-cycle pulse: arm receiver for one block
block_size_i  in  MaxBlockBitSize  block length in bytes, sampled at start_i
bus_width_is_4_i  in  1  1 = 4-bit bus, 0 = 1-bit (DAT0 only), sampled at start_i
data_o  out  32  received word; first byte on wire in [7:0]
data_valid_o  out  1  one-cycle strobe, data_o valid
done_o  out  1  one-cycle pulse, block finished or aborted
crc_err_o  out  1  valid with done_o; 0 otherwise
end_bit_err_o  out  1  valid with done_o; 0 otherwise
timeout_err_o  out  1  valid with done_o; 0 otherwise

Behaviour:
- Clocking: one clock (sd_clk_i); reset asynchronous, active-low (rst_ni).
- Reset: state READY, counters/shift register 0; all outputs 0 (data_o = 0).
- States: READY, WAIT_START, DAT, CRC, END_BIT, DONE.
- READY: on start_i, latch block_size_i and bus_width_is_4_i, clear the CRC lanes, go to WAIT_START. start_i in any other state is ignored.
- WAIT_START: sample dat_i[0]; 0 = start bit, go to DAT with counter = 0.
- DAT: one sample per cycle.
  - Required cycles: 2*block_size (4-bit) or 8*block_size (1-bit); counter is MaxBlockBitSize+4 bits wide, no overflow.
  - Byte assembly is MSB first:
    - 4-bit: high nibble, then low nibble.
    - 1-bit: bit 7 down to bit 0 on DAT0.
  - Bytes pack little-endian: byte k of a word lands in [8k+7:8k].
  - data_valid_o rises in the cycle after the last sample of each 4th byte; data_o is held until the next strobe.
  - block_size not a multiple of 4: the final partial word is emitted after the last byte, upper bytes zero.
  - block_size = 0: skip DAT, go straight to CRC.
- CRC: 16 cycles; each active lane's received bit is compared against its computed CRC16 (x^16+x^12+x^5+1, MSB first). Any mismatch sets the sticky crc_err. 1-bit mode checks lane 0 only; lanes 3:1 are ignored.
- END_BIT: every active lane must read 1, else set end_bit_err.
- DONE: done_o = 1 for one cycle with flags driven, then READY.
- Latency: done_o is two cycles after the last CRC bit is sampled.
- Flags are cleared on entry to WAIT_START.

Optional Feature:
READ_TIMEOUT_EN
- Defined: WAIT_START counts cycles. When the count reaches TimeoutCycles with no start bit, go to DONE with timeout_err_o=1, crc_err_o=0, end_bit_err_o=0, and no data_valid_o. A start bit seen in the same cycle as the limit wins.
- Undefined: WAIT_START waits indefinitely; timeout_err_o is tied to 0 and no counter is built.

Decomposition:
- Package sd_dat_pkg:
  - dat_rx_state_e
  - CRC16 polynomial constant
  - CrcLen = 16
- Sub-module crc16_read, one instance per lane:
  - ports: clk, rst_ni, clear, enable, serial-in data bit
  - 16-bit remainder output
  - also used for comparison in CRC state

Test Plan:
- 4-bit, block_size 512, bytes 0x00..0xFF repeating, valid CRCs -> 128 strobes, first data_o 0x03020100, last 0xFFFEFDFC; done_o with all flags 0.
- 1-bit, block_size 6, bytes A5 5A 3C C3 01 02, valid CRC -> data_o 0xC33C5AA5, then 0x00000201; crc_err_o=0.
- 4-bit, 512 bytes, DAT2 CRC bit 5 flipped -> done_o with crc_err_o=1, end_bit_err_o=0, all 128 words still delivered.
- 1-bit, block_size 4, end bit driven 0 on DAT0 -> end_bit_err_o=1, crc_err_o=0. Repeat with DAT3 end bit 0 in 1-bit mode -> end_bit_err_o=0 (lane ignored).
- READ_TIMEOUT_EN, TimeoutCycles=100, DAT held high -> done_o at cycle ~101 after start_i with timeout_err_o=1, no strobes. Start bit exactly at the limit -> normal receive.
- rst_ni low mid-DAT (after 37 nibbles) -> all outputs 0 asynchronously, state READY. A new start_i then receives a full clean block correctly.

Source files
------------

// File: rtl/sd_dat_pkg.sv
// Shared definitions for the SD data-line receive path: FSM states and CRC16 constants.
// Latency: n/a. Backpressure: n/a.
package sd_dat_pkg;

  localparam int CrcLen = 16;
  localparam logic [CrcLen-1:0] Crc16Poly = 16'h1021;  // x^16 + x^12 + x^5 + 1

  typedef enum logic [2:0] {
    RX_READY      = 3'd0,
    RX_WAIT_START = 3'd1,
    RX_DAT        = 3'd2,
    RX_CRC        = 3'd3,
    RX_END_BIT    = 3'd4,
    RX_DONE       = 3'd5
  } dat_rx_state_e;

endpackage

// File: rtl/crc16_read.sv
// Per-lane serial CRC16 accumulator, MSB-first, over the received data bits.
// Latency: remainder updates on the edge that samples bit_i. Backpressure: none.
// Hold enable_i low to freeze the remainder while it is compared against the card's CRC.
module crc16_read
  import sd_dat_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic              bit_i,
  output logic [CrcLen-1:0] crc_o
);

  logic fb;
  assign fb = bit_i ^ crc_o[CrcLen-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_o <= '0;
    end else if (clear_i) begin
      crc_o <= '0;
    end else if (enable_i) begin
      crc_o <= {crc_o[CrcLen-2:0], 1'b0} ^ (fb ? Crc16Poly : '0);
    end
  end

endmodule

// File: rtl/dat_read.sv
// SD host data-block receiver: start bit, 1/4-bit deserialise to 32-bit words, CRC16 + end-bit check.
// Latency: word strobe 1 cycle after its last sample; done_o 2 cycles after last CRC bit.
// Backpressure: none, the consumer must take every data_valid_o strobe. Optional READ_TIMEOUT_EN.
module dat_read
  import sd_dat_pkg::*;
#(
  parameter int MaxBlockBitSize = 12,
  parameter int TimeoutCycles   = 65535
) (
  input  logic                       sd_clk_i,
  input  logic                       rst_ni,
  input  logic [3:0]                 dat_i,
  input  logic                       start_i,
  input  logic [MaxBlockBitSize-1:0] block_size_i,
  input  logic                       bus_width_is_4_i,
  output logic [31:0]                data_o,
  output logic                       data_valid_o,
  output logic                       done_o,
  output logic                       crc_err_o,
  output logic                       end_bit_err_o,
  output logic                       timeout_err_o
);

  localparam int CntW = MaxBlockBitSize + 4;

  localparam logic [2:0] S_READY      = 3'(RX_READY);
  localparam logic [2:0] S_WAIT_START = 3'(RX_WAIT_START);
  localparam logic [2:0] S_DAT        = 3'(RX_DAT);
  localparam logic [2:0] S_CRC        = 3'(RX_CRC);
  localparam logic [2:0] S_END_BIT    = 3'(RX_END_BIT);
  localparam logic [2:0] S_DONE       = 3'(RX_DONE);

  logic [2:0]                 state;
  logic [CntW-1:0]            cnt;
  logic [MaxBlockBitSize-1:0] bs_q;
  logic                       bw4_q;
  logic [6:0]                 byte_sr;
  logic [31:0]                word_acc;
  logic [1:0]                 bidx;
  logic                       crc_err_q;
  logic                       end_err_q;

  logic [CntW-1:0] total;
  logic            last_sample;
  logic [7:0]      byte_nxt;
  logic            byte_done;
  logic [31:0]     word_nxt;
  logic [3:0]      lane_en;
  logic [3:0]      crc_exp;
  logic            crc_mis;
  logic            to_hit;
  logic            crc_clear;
  logic            crc_en;
  logic [CrcLen-1:0] crc_rem [4];

  assign total       = bw4_q ? {3'b000, bs_q, 1'b0} : {1'b0, bs_q, 3'b000};
  assign last_sample = (cnt == total - 1'b1);
  assign byte_nxt    = bw4_q ? {byte_sr[3:0], dat_i} : {byte_sr, dat_i[0]};
  assign byte_done   = bw4_q ? cnt[0] : (cnt[2:0] == 3'b111);
  assign lane_en     = bw4_q ? 4'hF : 4'h1;
  assign crc_clear   = (state == S_READY) && start_i;
  assign crc_en      = (state == S_DAT);

  always_comb begin
    word_nxt = word_acc;
    word_nxt[{bidx, 3'b000} +: 8] = byte_nxt;
  end

  // Remainders are frozen during CRC; the card's CRC bits are checked MSB first.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    crc16_read u_crc (
      .clk_i    (sd_clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (crc_clear),
      .enable_i (crc_en),
      .bit_i    (dat_i[l]),
      .crc_o    (crc_rem[l])
    );
    assign crc_exp[l] = crc_rem[l][4'd15 - cnt[3:0]];
  end

  assign crc_mis = |(lane_en & (crc_exp ^ dat_i));

`ifdef READ_TIMEOUT_EN
  localparam int ToW = $clog2(TimeoutCycles + 1);
  logic [ToW-1:0] to_cnt;
  logic           to_err_q;

  assign to_hit = (state == S_WAIT_START) && dat_i[0] &&
                  (to_cnt >= ToW'(TimeoutCycles - 1));

  always_ff @(posedge sd_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt        <= '0;
      to_err_q      <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      timeout_err_o <= 1'b0;
      if (crc_clear) begin
        to_cnt   <= '0;
        to_err_q <= 1'b0;
      end else if (to_hit) begin
        to_err_q <= 1'b1;
      end else if (state == S_WAIT_START && dat_i[0]) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (state == S_DONE) timeout_err_o <= to_err_q;
    end
  end
`else
  assign to_hit        = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge sd_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_READY;
      cnt           <= '0;
      bs_q          <= '0;
      bw4_q         <= 1'b0;
      byte_sr       <= '0;
      word_acc      <= '0;
      bidx          <= '0;
      crc_err_q     <= 1'b0;
      end_err_q     <= 1'b0;
      data_o        <= '0;
      data_valid_o  <= 1'b0;
      done_o        <= 1'b0;
      crc_err_o     <= 1'b0;
      end_bit_err_o <= 1'b0;
    end else begin
      data_valid_o  <= 1'b0;
      done_o        <= 1'b0;
      crc_err_o     <= 1'b0;
      end_bit_err_o <= 1'b0;
      case (state)
        S_READY: begin
          if (start_i) begin
            bs_q      <= block_size_i;
            bw4_q     <= bus_width_is_4_i;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            state     <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (!dat_i[0]) begin
            cnt      <= '0;
            bidx     <= '0;
            word_acc <= '0;
            state    <= (bs_q == '0) ? S_CRC : S_DAT;
          end else if (to_hit) begin
            state <= S_DONE;
          end
        end
        S_DAT: begin
          byte_sr <= byte_nxt[6:0];
          cnt     <= cnt + 1'b1;
          if (byte_done) begin
            bidx <= bidx + 1'b1;
            // A word leaves when full or when the block ends; unused upper bytes stay zero.
            if (bidx == 2'd3 || last_sample) begin
              data_o       <= word_nxt;
              data_valid_o <= 1'b1;
              word_acc     <= '0;
            end else begin
              word_acc <= word_nxt;
            end
          end
          if (last_sample) begin
            cnt   <= '0;
            state <= S_CRC;
          end
        end
        S_CRC: begin
          if (crc_mis) crc_err_q <= 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt == CntW'(CrcLen - 1)) state <= S_END_BIT;
        end
        S_END_BIT: begin
          if (|(lane_en & ~dat_i)) end_err_q <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done_o        <= 1'b1;
          crc_err_o     <= crc_err_q;
          end_bit_err_o <= end_err_q;
          state         <= S_READY;
        end
        default: state <= S_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_dat_read.sv
// Scoreboard bench for dat_read: drives SD data blocks, checks words, flags and done latency.
// Timeout cases are exercised only when READ_TIMEOUT_EN is defined.
module tb_dat_read;

`ifdef READ_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic        sd_clk_i = 1'b0;
  logic        rst_ni   = 1'b0;
  logic [3:0]  dat_i    = 4'hF;
  logic        start_i  = 1'b0;
  logic [11:0] block_size_i = '0;
  logic        bus_width_is_4_i = 1'b0;
  logic [31:0] data_o;
  logic        data_valid_o, done_o, crc_err_o, end_bit_err_o, timeout_err_o;

  dat_read #(.MaxBlockBitSize(12), .TimeoutCycles(TO)) dut (
    .sd_clk_i         (sd_clk_i),
    .rst_ni           (rst_ni),
    .dat_i            (dat_i),
    .start_i          (start_i),
    .block_size_i     (block_size_i),
    .bus_width_is_4_i (bus_width_is_4_i),
    .data_o           (data_o),
    .data_valid_o     (data_valid_o),
    .done_o           (done_o),
    .crc_err_o        (crc_err_o),
    .end_bit_err_o    (end_bit_err_o),
    .timeout_err_o    (timeout_err_o)
  );

  always #5 sd_clk_i = ~sd_clk_i;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          strobe_cnt = 0;
  logic [31:0] sb [$];
  logic [7:0]  blk [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  always @(negedge sd_clk_i) begin
    if (data_valid_o) begin
      strobe_cnt++;
      if (sb.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
      else chk("word", data_o, sb.pop_front());
    end
  end

  task automatic drive(input logic [3:0] v, inout logic [15:0] crc [4]);
    @(negedge sd_clk_i);
    dat_i = v;
    for (int l = 0; l < 4; l++) crc[l] = crc_step(crc[l], v[l]);
  endtask

  // Sends blk[0..bs-1]; returns cycles from end bit to done_o.
  task automatic send_block(input bit bw4, input int bs, input int idle, input int flip_lane,
                            input int flip_bit, input logic [3:0] end_val, output int lat);
    logic [15:0] crc [4];
    logic [31:0] w;
    logic [7:0]  b;
    logic [3:0]  v;
    for (int l = 0; l < 4; l++) crc[l] = 16'h0;
    for (int i = 0; i < (bs + 3) / 4; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) if (4 * i + k < bs) w[8*k +: 8] = blk[4*i+k];
      sb.push_back(w);
    end
    @(negedge sd_clk_i);
    start_i = 1'b1; block_size_i = 12'(bs); bus_width_is_4_i = bw4; dat_i = 4'hF;
    @(negedge sd_clk_i);
    start_i = 1'b0;
    for (int i = 1; i < idle; i++) @(negedge sd_clk_i);
    @(negedge sd_clk_i);
    dat_i = bw4 ? 4'h0 : 4'hE;
    for (int i = 0; i < 4; i++) crc[i] = 16'h0;
    for (int i = 0; i < bs; i++) begin
      b = blk[i];
      if (bw4) begin
        drive(b[7:4], crc);
        drive(b[3:0], crc);
      end else begin
        for (int j = 7; j >= 0; j--) drive({3'b111, b[j]}, crc);
      end
    end
    for (int i = 15; i >= 0; i--) begin
      @(negedge sd_clk_i);
      for (int l = 0; l < 4; l++) v[l] = crc[l][i] ^ (l == flip_lane && i == flip_bit);
      dat_i = bw4 ? v : {3'b111, v[0]};
    end
    @(negedge sd_clk_i);
    dat_i = end_val;
    lat = 0;
    do begin
      @(negedge sd_clk_i);
      dat_i = 4'hF;
      lat++;
    end while (!done_o && lat < 20);
  endtask

  task automatic run_case(input string tag, input bit bw4, input int bs, input int idle,
                          input int flip_lane, input int flip_bit, input logic [3:0] end_val,
                          input logic exp_crc, input logic exp_end);
    int lat;
    strobe_cnt = 0;
    send_block(bw4, bs, idle, flip_lane, flip_bit, end_val, lat);
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_crc_err"}, {31'b0, crc_err_o}, {31'b0, exp_crc});
    chk({tag, "_end_err"}, {31'b0, end_bit_err_o}, {31'b0, exp_end});
    chk({tag, "_to_err"}, {31'b0, timeout_err_o}, 32'd0);
    chk({tag, "_strobes"}, 32'(strobe_cnt), 32'((bs + 3) / 4));
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_data"}, data_o, 32'h0);
    chk({tag, "_flags"}, {26'b0, data_valid_o, done_o, crc_err_o, end_bit_err_o, timeout_err_o, 1'b0}, 32'h0);
  endtask

  initial begin
    logic [15:0] dummy [4];
    int lat;
    #12;
    check_idle_outputs("reset");
    @(negedge sd_clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 4096; i++) blk[i] = 8'(i);
    run_case("b4_512", 1'b1, 512, 2, -1, 0, 4'hF, 1'b0, 1'b0);
    chk("b4_512_last_word", data_o, 32'hFFFEFDFC);

    blk[0] = 8'hA5; blk[1] = 8'h5A; blk[2] = 8'h3C; blk[3] = 8'hC3; blk[4] = 8'h01; blk[5] = 8'h02;
    run_case("b1_6", 1'b0, 6, 3, -1, 0, 4'hF, 1'b0, 1'b0);
    chk("b1_6_partial_word", data_o, 32'h00000201);

    for (int i = 0; i < 4096; i++) blk[i] = 8'(i);
    run_case("b4_crcflip", 1'b1, 512, 1, 2, 5, 4'hF, 1'b1, 1'b0);

    blk[0] = 8'h11; blk[1] = 8'h22; blk[2] = 8'h33; blk[3] = 8'h44;
    run_case("b1_end0", 1'b0, 4, 2, -1, 0, 4'hE, 1'b0, 1'b1);
    run_case("b1_dat3end0", 1'b0, 4, 2, -1, 0, 4'h7, 1'b0, 1'b0);
    run_case("b4_end_dat1", 1'b1, 4, 2, -1, 0, 4'hD, 1'b0, 1'b1);
    run_case("b4_empty", 1'b1, 0, 2, -1, 0, 4'hF, 1'b0, 1'b0);

`ifdef READ_TIMEOUT_EN
    strobe_cnt = 0;
    @(negedge sd_clk_i);
    start_i = 1'b1; block_size_i = 12'd4; bus_width_is_4_i = 1'b0; dat_i = 4'hF;
    @(negedge sd_clk_i);
    start_i = 1'b0;
    lat = 0;
    while (!done_o && lat < 300) begin
      @(negedge sd_clk_i);
      lat++;
    end
    chk("to_latency", 32'(lat), 32'(TO + 1));
    chk("to_flag", {29'b0, timeout_err_o, crc_err_o, end_bit_err_o}, 32'h4);
    chk("to_strobes", 32'(strobe_cnt), 32'd0);
    run_case("to_limit_start", 1'b0, 4, TO - 1, -1, 0, 4'hF, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of a 4-bit block, after 37 nibbles.
    for (int i = 0; i < 4096; i++) blk[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 4; i++) dummy[i] = 16'h0;
    for (int i = 0; i < 4; i++) sb.push_back({blk[4*i+3], blk[4*i+2], blk[4*i+1], blk[4*i]});
    strobe_cnt = 0;
    @(negedge sd_clk_i);
    start_i = 1'b1; block_size_i = 12'd512; bus_width_is_4_i = 1'b1; dat_i = 4'hF;
    @(negedge sd_clk_i);
    start_i = 1'b0;
    @(negedge sd_clk_i);
    dat_i = 4'h0;
    for (int n = 0; n < 37; n++) drive(n[0] ? blk[n/2][3:0] : blk[n/2][7:4], dummy);
    @(posedge sd_clk_i);
    #2;
    chk("mid_strobes", 32'(strobe_cnt), 32'd4);
    chk("mid_sb_left", 32'(sb.size()), 32'd0);
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    @(negedge sd_clk_i);
    dat_i = 4'hF;
    rst_ni = 1'b1;
    run_case("post_rst", 1'b1, 512, 2, -1, 0, 4'hF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
